// File: rtl/fast_nms_if.sv
// Score-stream / NMS-result bundle for fast_nms.
// Handshake: a beat transfers on every rising edge where in_valid=1 (no ready, the sink
// always accepts); out_valid marks a one-cycle result and fields hold while it is low.
interface fast_nms_if #(
    parameter int DATA_WIDTH = 8,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9
);
    logic                  in_valid;
    logic                  in_sof;
    logic [DATA_WIDTH-1:0] in_score;
    logic                  out_valid;
    logic                  out_corner;
    logic [DATA_WIDTH-1:0] out_score;
    logic [X_WIDTH-1:0]    out_x;
    logic [Y_WIDTH-1:0]    out_y;
    logic                  frame_done;

    modport master (
        output in_valid, in_sof, in_score,
        input  out_valid, out_corner, out_score, out_x, out_y, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_score,
        output out_valid, out_corner, out_score, out_x, out_y, frame_done
    );
endinterface

// File: rtl/fast_nms.sv
// 3x3 non-maximum suppression over a raster stream of FAST corner scores.
// Two line buffers feed a 3x3 window; one registered result per interior pixel.
module fast_nms #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9
) (
    input  logic     clk,
    input  logic     rst,
    fast_nms_if.slave nms
);
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(IMG_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [X_WIDTH-1:0] X_TWO  = X_WIDTH'(2);
    localparam logic [Y_WIDTH-1:0] Y_TWO  = Y_WIDTH'(2);

    logic [DATA_WIDTH-1:0] line1_mem [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line2_mem [IMG_WIDTH];

    logic [X_WIDTH-1:0]    col_q, col_d, cur_col;
    logic [Y_WIDTH-1:0]    row_q, row_d, cur_row;
    logic [DATA_WIDTH-1:0] win_q [3][3];
    logic [DATA_WIDTH-1:0] win_d [3][3];

    logic                  out_valid_q, out_valid_d;
    logic                  out_corner_q, out_corner_d;
    logic [DATA_WIDTH-1:0] out_score_q, out_score_d;
    logic [X_WIDTH-1:0]    out_x_q, out_x_d;
    logic [Y_WIDTH-1:0]    out_y_q, out_y_d;
    logic                  frame_done_q, frame_done_d;

    logic                  complete;
    logic                  is_max;
    logic [DATA_WIDTH-1:0] c;

    always_comb begin
        cur_col      = (nms.in_valid && nms.in_sof) ? '0 : col_q;
        cur_row      = (nms.in_valid && nms.in_sof) ? '0 : row_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_corner_d = out_corner_q;
        out_score_d  = out_score_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;

        if (nms.in_valid) begin
            if (cur_col == X_LAST) begin
                col_d = '0;
                row_d = (cur_row == Y_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = line2_mem[cur_col];
            win_d[1][2] = line1_mem[cur_col];
            win_d[2][2] = nms.in_score;
        end

        // Row 0 is two lines up, column 2 is the newest column; centre is [1][1].
        // Raster-earlier neighbours must be strictly smaller so a plateau keeps its first pixel.
        c      = win_d[1][1];
        is_max = (c != '0)
              && (c >  win_d[0][0]) && (c >  win_d[0][1]) && (c >  win_d[0][2])
              && (c >  win_d[1][0]) && (c >= win_d[1][2])
              && (c >= win_d[2][0]) && (c >= win_d[2][1]) && (c >= win_d[2][2]);

        complete = nms.in_valid && (cur_col >= X_TWO) && (cur_row >= Y_TWO);
        if (complete) begin
            out_valid_d  = 1'b1;
            out_corner_d = is_max;
            out_score_d  = c;
            out_x_d      = cur_col - 1'b1;
            out_y_d      = cur_row - 1'b1;
            frame_done_d = (cur_col == X_LAST) && (cur_row == Y_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            out_valid_q  <= 1'b0;
            out_corner_q <= 1'b0;
            out_score_q  <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            out_corner_q <= out_corner_d;
            out_score_q  <= out_score_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers are never reset; the col/row >= 2 gate hides stale lines.
    always_ff @(posedge clk) begin
        if (nms.in_valid) begin
            line1_mem[cur_col] <= nms.in_score;
            line2_mem[cur_col] <= line1_mem[cur_col];
        end
    end

    assign nms.out_valid  = out_valid_q;
    assign nms.out_corner = out_corner_q;
    assign nms.out_score  = out_score_q;
    assign nms.out_x      = out_x_q;
    assign nms.out_y      = out_y_q;
    assign nms.frame_done = frame_done_q;
endmodule

// File: tb/tb_fast_nms.sv
// Self-checking bench for fast_nms on an 8x6 image against a frame-level NMS model.
module tb_fast_nms;
  localparam int W = 8;
  localparam int H = 6;
  localparam int RW = 16;

  logic clk;
  logic rst;

  fast_nms_if #(.DATA_WIDTH(8), .X_WIDTH(3), .Y_WIDTH(3)) nif ();

  fast_nms #(
    .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .X_WIDTH(3), .Y_WIDTH(3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .nms (nif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int frame_img [H][W];
  int mimg [H][W];
  int pos_x, pos_y;
  logic [RW-1:0] exp_q [$];
  logic [7:0] last_score;
  logic [2:0] last_x, last_y;
  logic       last_corner;
  int cnt_valid, cnt_corner, cnt_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_corner(int cx, int cy);
    int cv;
    cv = mimg[cy][cx];
    if (cv == 0) return 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dy == 0 && dx == 0) continue;
        if (dy < 0 || (dy == 0 && dx < 0)) begin
          if (!(cv > mimg[cy+dy][cx+dx])) return 1'b0;
        end else if (cv < mimg[cy+dy][cx+dx]) begin
          return 1'b0;
        end
      end
    end
    return 1'b1;
  endfunction

  task automatic tick(input logic v, input logic s, input logic [7:0] sc, input logic r);
    logic [RW-1:0] e;
    bit pushed;
    pushed = 1'b0;
    nif.in_valid = v;
    nif.in_sof   = s;
    nif.in_score = sc;
    rst          = r;
    if (r) begin
      pos_x = 0;
      pos_y = 0;
      last_score = '0; last_x = '0; last_y = '0; last_corner = 1'b0;
      exp_q.delete();
    end else if (v) begin
      if (s) begin
        pos_x = 0;
        pos_y = 0;
      end
      mimg[pos_y][pos_x] = int'(sc);
      if (pos_x >= 2 && pos_y >= 2) begin
        exp_q.push_back({(pos_x == W-1 && pos_y == H-1), ref_corner(pos_x-1, pos_y-1),
                         8'(mimg[pos_y-1][pos_x-1]), 3'(pos_y-1), 3'(pos_x-1)});
        pushed = 1'b1;
      end
      pos_x++;
      if (pos_x == W) begin
        pos_x = 0;
        pos_y = (pos_y == H-1) ? 0 : pos_y + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (nif.out_valid === 1'b1) cnt_valid++;
    if (nif.out_valid === 1'b1 && nif.out_corner === 1'b1) cnt_corner++;
    if (nif.frame_done === 1'b1) cnt_fd++;
    if (r) begin
      check("rst_valid", 32'(nif.out_valid), 0);
      check("rst_corner", 32'(nif.out_corner), 0);
      check("rst_score", 32'(nif.out_score), 0);
      check("rst_x", 32'(nif.out_x), 0);
      check("rst_y", 32'(nif.out_y), 0);
      check("rst_frame_done", 32'(nif.frame_done), 0);
    end else if (pushed) begin
      e = exp_q.pop_front();
      check("valid", 32'(nif.out_valid), 1);
      check("x", 32'(nif.out_x), 32'(e[2:0]));
      check("y", 32'(nif.out_y), 32'(e[5:3]));
      check("score", 32'(nif.out_score), 32'(e[13:6]));
      check("corner", 32'(nif.out_corner), 32'(e[14]));
      check("frame_done", 32'(nif.frame_done), 32'(e[15]));
      last_x = e[2:0]; last_y = e[5:3]; last_score = e[13:6]; last_corner = e[14];
    end else begin
      check("idle_valid", 32'(nif.out_valid), 0);
      check("idle_frame_done", 32'(nif.frame_done), 0);
      check("hold_x", 32'(nif.out_x), 32'(last_x));
      check("hold_y", 32'(nif.out_y), 32'(last_y));
      check("hold_score", 32'(nif.out_score), 32'(last_score));
      check("hold_corner", 32'(nif.out_corner), 32'(last_corner));
    end
  endtask

  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        frame_img[y][x] = 0;
  endtask

  task automatic random_img(input int maxv);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        frame_img[y][x] = $urandom_range(maxv, 0);
  endtask

  task automatic send_frame(input int gmin, input int gmax, input bit use_sof);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int g;
        g = $urandom_range(gmax, gmin);
        repeat (g) tick(1'b0, 1'($urandom), 8'($urandom), 1'b0);
        tick(1'b1, use_sof && x == 0 && y == 0, 8'(frame_img[y][x]), 1'b0);
      end
    end
    repeat (2) tick(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic frame_counts(input string tag, input int v0, input int c0, input int f0,
                              input int exp_corners);
    check({tag, "_valid_count"}, 32'(cnt_valid - v0), 24);
    check({tag, "_frame_done_count"}, 32'(cnt_fd - f0), 1);
    if (exp_corners >= 0) check({tag, "_corner_count"}, 32'(cnt_corner - c0), 32'(exp_corners));
  endtask

  initial begin
    int v0, c0, f0;
    pos_x = 0; pos_y = 0;
    last_score = '0; last_x = '0; last_y = '0; last_corner = 1'b0;
    cnt_valid = 0; cnt_corner = 0; cnt_fd = 0;
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) mimg[y][x] = 0;
    nif.in_valid = 1'b0; nif.in_sof = 1'b0; nif.in_score = '0; rst = 1'b1;
    @(negedge clk);
    repeat (2) tick(1'b0, 1'b0, 8'h00, 1'b1);

    // all-zero frame
    clear_img();
    v0 = cnt_valid; c0 = cnt_corner; f0 = cnt_fd;
    send_frame(0, 0, 1'b1);
    frame_counts("zero", v0, c0, f0, 0);

    // single peak
    clear_img();
    frame_img[2][3] = 50;
    v0 = cnt_valid; c0 = cnt_corner; f0 = cnt_fd;
    send_frame(0, 0, 1'b1);
    frame_counts("peak", v0, c0, f0, 1);

    // plateau of two equal scores
    clear_img();
    frame_img[3][3] = 40;
    frame_img[3][4] = 40;
    v0 = cnt_valid; c0 = cnt_corner; f0 = cnt_fd;
    send_frame(0, 0, 1'b1);
    frame_counts("plateau", v0, c0, f0, 1);

    // single peak, one beat every third cycle
    clear_img();
    frame_img[2][3] = 50;
    v0 = cnt_valid; c0 = cnt_corner; f0 = cnt_fd;
    send_frame(2, 2, 1'b1);
    frame_counts("sparse", v0, c0, f0, 1);

    // random frames: small range for frequent ties, then full range with gaps
    for (int k = 0; k < 3; k++) begin
      random_img(3);
      v0 = cnt_valid; c0 = cnt_corner; f0 = cnt_fd;
      send_frame(0, 2, 1'b1);
      frame_counts("rand_small", v0, c0, f0, -1);
    end
    random_img(255);
    v0 = cnt_valid; c0 = cnt_corner; f0 = cnt_fd;
    send_frame(0, 1, 1'b1);
    frame_counts("rand_full", v0, c0, f0, -1);

    // mid-frame restart: 19 beats of one frame, sof on the 20th beat
    random_img(255);
    f0 = cnt_fd;
    for (int i = 0; i < 19; i++)
      tick(1'b1, i == 0, 8'(frame_img[i / W][i % W] ^ 8'h5a), 1'b0);
    check("abort_no_frame_done", 32'(cnt_fd - f0), 0);
    v0 = cnt_valid; c0 = cnt_corner; f0 = cnt_fd;
    send_frame(0, 0, 1'b1);
    frame_counts("restart", v0, c0, f0, -1);

    // reset on a completing beat mid-frame, then a frame without sof
    random_img(255);
    for (int i = 0; i < 26; i++)
      tick(1'b1, i == 0, 8'(frame_img[i / W][i % W]), 1'b0);
    tick(1'b1, 1'b0, 8'hff, 1'b1);
    random_img(255);
    v0 = cnt_valid; c0 = cnt_corner; f0 = cnt_fd;
    send_frame(0, 1, 1'b0);
    frame_counts("post_reset", v0, c0, f0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
